spi_rdid_engine: RTL and testbench

SPI master that executes the M25P16 RDID (0x9F) transaction and returns the three JEDEC ID bytes. It sits between the debounced get-RDID pulse and the LED/LCD display logic inside `command`. It drives SPICLK, SPIMOSI and cs_prom_n, and samples SPIMISO. The display mux reads only the registered ID bytes.

---
 rtl/spi_rdid_engine.sv | 150 +++++++++++++++
 tb/tb_spi_rdid_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rdid_engine.sv
// SPI mode-0 master for the M25P16 RDID (0x9F) command; returns the three JEDEC ID bytes.
// The ID registers update only in the DONE cycle, so the display never sees a partial ID.
module spi_rdid_engine #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned DESEL_CYC = 5
) (
  input  logic       CCLK,
  input  logic       reset,
  input  logic       start,
  input  logic       SPIMISO,
  output logic       SPICLK,
  output logic       SPIMOSI,
  output logic       cs_prom_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] man_id,
  output logic [7:0] mem_type,
  output logic [7:0] mem_cap
);

  localparam logic [7:0] RDID     = 8'h9F;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam int         DW       = (DESEL_CYC < 1) ? 1 : $clog2(DESEL_CYC + 1);
  localparam logic [DW-1:0] DESEL_INIT = DW'(DESEL_CYC);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t        state, state_nx;
  logic [7:0]    div_cnt, div_cnt_nx;
  logic [4:0]    bit_cnt, bit_cnt_nx;
  logic [4:0]    bit_inc;
  logic [DW-1:0] desel_cnt, desel_cnt_nx;
  logic [23:0]   shadow, shadow_nx;
  logic          sclk_nx, mosi_nx, cs_nx, busy_nx, done_nx;
  logic [7:0]    man_nx, type_nx, cap_nx;
  logic          div_end;

  assign div_end = (div_cnt == DIV_LAST);
  assign bit_inc = bit_cnt + 5'd1;

  always_comb begin
    state_nx     = state;
    div_cnt_nx   = div_cnt;
    bit_cnt_nx   = bit_cnt;
    desel_cnt_nx = desel_cnt;
    shadow_nx    = shadow;
    sclk_nx      = SPICLK;
    mosi_nx      = SPIMOSI;
    cs_nx        = cs_prom_n;
    busy_nx      = busy;
    done_nx      = 1'b0;
    man_nx       = man_id;
    type_nx      = mem_type;
    cap_nx       = mem_cap;

    // Deselect timer free-runs down to zero; DONE reloads it below.
    if (desel_cnt != '0) desel_cnt_nx = desel_cnt - 1'b1;

    unique case (state)
      IDLE: begin
        if (start && (desel_cnt == '0)) begin
          state_nx   = SETUP;
          div_cnt_nx = '0;
          cs_nx      = 1'b0;
          busy_nx    = 1'b1;
          sclk_nx    = 1'b0;
          mosi_nx    = RDID[7];
        end
      end
      SETUP: begin
        if (div_end) begin
          state_nx   = SHIFT;
          div_cnt_nx = '0;
          bit_cnt_nx = '0;
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end
      SHIFT: begin
        div_cnt_nx = div_cnt + 8'd1;
        if (div_end) begin
          div_cnt_nx = '0;
          if (!SPICLK) begin
            // Rising edge: the flash has held MISO stable since the previous fall.
            sclk_nx = 1'b1;
            if (bit_cnt >= 5'd8) shadow_nx = {shadow[22:0], SPIMISO};
          end else if (bit_cnt == 5'd31) begin
            sclk_nx  = 1'b0;
            mosi_nx  = 1'b0;
            state_nx = HOLD;
          end else begin
            sclk_nx    = 1'b0;
            bit_cnt_nx = bit_inc;
            mosi_nx    = (bit_inc < 5'd8) ? RDID[~bit_inc[2:0]] : 1'b0;
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          state_nx     = DONE;
          div_cnt_nx   = '0;
          cs_nx        = 1'b1;
          busy_nx      = 1'b0;
          done_nx      = 1'b1;
          man_nx       = shadow[23:16];
          type_nx      = shadow[15:8];
          cap_nx       = shadow[7:0];
          desel_cnt_nx = DESEL_INIT;
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CCLK) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      desel_cnt <= DESEL_INIT;
      shadow    <= '0;
      SPICLK    <= 1'b0;
      SPIMOSI   <= 1'b0;
      cs_prom_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      man_id    <= '0;
      mem_type  <= '0;
      mem_cap   <= '0;
    end else begin
      state     <= state_nx;
      div_cnt   <= div_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      desel_cnt <= desel_cnt_nx;
      shadow    <= shadow_nx;
      SPICLK    <= sclk_nx;
      SPIMOSI   <= mosi_nx;
      cs_prom_n <= cs_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      man_id    <= man_nx;
      mem_type  <= type_nx;
      mem_cap   <= cap_nx;
    end
  end

endmodule

// File: tb/tb_spi_rdid_engine.sv
// Bench for spi_rdid_engine: three instances (CLK_DIV 2/1/3), each with a behavioural
// M25P16 RDID responder and a bus monitor measuring cs/SPICLK timing and done behaviour.
module tb_spi_rdid_engine;

  localparam int NI = 3;
  localparam int DIVS [NI] = '{2, 1, 3};
  localparam int DESEL = 5;

  logic CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  logic          reset = 1'b1;
  logic [NI-1:0] start_v = '0;
  logic [NI-1:0] spiclk_v, mosi_v, cs_v, busy_v, done_v;
  logic [7:0]    man_v [NI];
  logic [7:0]    type_v [NI];
  logic [7:0]    cap_v [NI];
  logic [23:0]   flash_id [NI];
  int            mon_cs_low [NI];
  int            mon_cs_high [NI];
  int            mon_rises [NI];
  int            mon_ntx [NI];
  int            mon_dones [NI];
  int            mon_bad [NI];
  logic [31:0]   mon_mosi [NI];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N = DIVS[g];
    logic sclk, mosi, csn, bsy, dn;
    logic miso = 1'b0;
    logic [7:0] mi, mt, mc;

    spi_rdid_engine #(.CLK_DIV(N), .DESEL_CYC(DESEL)) dut (
      .CCLK(CCLK), .reset(reset), .start(start_v[g]), .SPIMISO(miso),
      .SPICLK(sclk), .SPIMOSI(mosi), .cs_prom_n(csn), .busy(bsy), .done(dn),
      .man_id(mi), .mem_type(mt), .mem_cap(mc)
    );

    assign spiclk_v[g] = sclk;
    assign mosi_v[g]   = mosi;
    assign cs_v[g]     = csn;
    assign busy_v[g]   = bsy;
    assign done_v[g]   = dn;
    assign man_v[g]    = mi;
    assign type_v[g]   = mt;
    assign cap_v[g]    = mc;

    int cs_low = 0, cs_high = 0, rises = 0, hi_run = 0, lo_run = 0;
    int low_last = 0, high_last = 0, rises_last = 0, ntx = 0, dones = 0, bad = 0;
    logic [31:0] msh = '0, mosi_last = '0;
    logic [7:0]  cmd = '0;
    logic [4:0]  bi;
    logic        csq = 1'b1, clkq = 1'b0, dnq = 1'b0, rstq = 1'b1, rst_seen = 1'b1;
    logic [23:0] resq = '0;

    assign mon_cs_low[g]  = low_last;
    assign mon_cs_high[g] = high_last;
    assign mon_rises[g]   = rises_last;
    assign mon_ntx[g]     = ntx;
    assign mon_dones[g]   = dones;
    assign mon_bad[g]     = bad;
    assign mon_mosi[g]    = mosi_last;

    // Monitor plus flash responder: ID bits leave on SPICLK falls once 0x9F has been clocked in.
    initial forever begin
      @(negedge CCLK);
      if (reset) rst_seen = 1'b1;
      if (csq && !csn) begin
        high_last = cs_high; cs_high = 0; rises = 0; msh = '0; lo_run = 0; rst_seen = reset;
      end
      if (!csq && csn) begin
        low_last = cs_low; cs_low = 0; rises_last = rises; mosi_last = msh; ntx++;
      end
      if (!clkq && sclk) begin
        if (!rst_seen && ((rises == 0) ? (cs_low != 2 * N) : (lo_run != N))) bad++;
        rises++;
        msh = {msh[30:0], mosi};
        lo_run = 0;
        if (rises == 8) cmd = msh[7:0];
      end
      if (clkq && !sclk) begin
        if (!rst_seen && hi_run != N) bad++;
        hi_run = 0;
        if (!csn && rises >= 8 && rises < 32 && cmd == 8'h9F) begin
          bi = 5'(31 - rises);
          miso = flash_id[g][bi];
        end
      end
      if (dn === 1'b1 && bsy === 1'b1) bad++;
      if (dn === 1'b1 && dnq === 1'b1) bad++;
      if (dn === 1'b1) dones++;
      if (dn === 1'b0 && !reset && !rstq && ({mi, mt, mc} !== resq)) bad++;
      if (csn === 1'b0) cs_low++; else cs_high++;
      if (sclk === 1'b1) hi_run++; else lo_run++;
      csq = csn; clkq = sclk; dnq = dn; rstq = reset; resq = {mi, mt, mc};
    end
  end

  task automatic tick();
    @(posedge CCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction on instance inst; p1/p2 are extra start pulses (edge index) that must be dropped.
  task automatic run_tx(input int inst, input logic [23:0] id, input int exp_cs, input int exp_lat,
                        input logic [23:0] exp_res, input int p1, input int p2, input string tag);
    int lat, d0, t0;
    flash_id[inst] = id;
    d0 = mon_dones[inst];
    t0 = mon_ntx[inst];
    start_v[inst] = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      start_v[inst] = (lat == p1 || lat == p2);
    end while (!done_v[inst] && lat < 4000);
    start_v[inst] = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_id"}, {40'd0, man_v[inst], type_v[inst], cap_v[inst]}, {40'd0, exp_res});
    tick();
    chk({tag, "_cs_low"}, 64'(mon_cs_low[inst]), 64'(exp_cs));
    chk({tag, "_rises"}, 64'(mon_rises[inst]), 64'd32);
    chk({tag, "_mosi"}, {32'd0, mon_mosi[inst]}, 64'h9F00_0000);
    chk({tag, "_ndone"}, 64'(mon_dones[inst] - d0), 64'd1);
    repeat (DESEL + 3) tick();
    chk({tag, "_no_queue"}, {62'd0, cs_v[inst], busy_v[inst]}, 64'd2);
    chk({tag, "_ntx"}, 64'(mon_ntx[inst] - t0), 64'd1);
  endtask

  typedef struct {
    int          inst;
    logic [23:0] id;
    int          exp_cs;
    int          exp_lat;
    logic [23:0] exp_res;
    int          p1;
    int          p2;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lat, d0, ri, rn, rp;
    logic [23:0] rid;

    tbl[0] = '{0, 24'h202015, 132, 133, 24'h202015, -1, -1};
    tbl[1] = '{1, 24'h202015,  66,  67, 24'h202015, -1, -1};
    tbl[2] = '{2, 24'h202015, 198, 199, 24'h202015, -1, -1};
    tbl[3] = '{0, 24'h202015, 132, 133, 24'h202015, 15, 83};
    tbl[4] = '{0, 24'hC35A81, 132, 133, 24'hC35A81, -1, -1};
    tbl[5] = '{1, 24'hFF00FF,  66,  67, 24'hFF00FF, -1, -1};
    for (int i = 0; i < NI; i++) flash_id[i] = 24'h202015;

    // Reset state, then the deselect window after reset.
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_outs", {59'd0, cs_v[0], spiclk_v[0], busy_v[0], done_v[0], mosi_v[0]}, 64'h10);
    chk("rst_id", {40'd0, man_v[0], type_v[0], cap_v[0]}, 64'd0);
    reset = 1'b0;
    tick();
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    chk("early_start_2", {63'd0, cs_v[0]}, 64'd1);
    tick(); tick();
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    chk("early_start_5", {63'd0, cs_v[0]}, 64'd1);
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    chk("start_6_accept", {61'd0, cs_v[0], busy_v[0], mosi_v[0]}, 64'h3);
    lat = 0;
    while (!done_v[0] && lat < 1000) begin tick(); lat++; end
    chk("first_done", {63'd0, done_v[0]}, 64'd1);
    chk("first_id", {40'd0, man_v[0], type_v[0], cap_v[0]}, 64'h202015);
    tick();
    chk("first_cs_low", 64'(mon_cs_low[0]), 64'd132);
    chk("first_rises", 64'(mon_rises[0]), 64'd32);
    chk("first_mosi", {32'd0, mon_mosi[0]}, 64'h9F00_0000);
    repeat (DESEL + 3) tick();

    for (int i = 0; i < 6; i++)
      run_tx(tbl[i].inst, tbl[i].id, tbl[i].exp_cs, tbl[i].exp_lat, tbl[i].exp_res,
             tbl[i].p1, tbl[i].p2, $sformatf("vec%0d", i));

    // Reset landing inside bit 12.
    flash_id[0] = 24'h202015;
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    repeat (51) tick();
    chk("mid_active", {62'd0, cs_v[0], busy_v[0]}, 64'd1);
    d0 = mon_dones[0];
    reset = 1'b1; tick();
    chk("mid_rst_outs", {59'd0, cs_v[0], spiclk_v[0], busy_v[0], done_v[0], mosi_v[0]}, 64'h10);
    chk("mid_rst_id", {40'd0, man_v[0], type_v[0], cap_v[0]}, 64'd0);
    reset = 1'b0;
    repeat (150) tick();
    chk("mid_rst_no_done", 64'(mon_dones[0] - d0), 64'd0);
    run_tx(0, 24'h202015, 132, 133, 24'h202015, -1, -1, "after_rst");

    // start held high: back-to-back transactions.
    d0 = mon_dones[0];
    start_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      while (!done_v[0] && lat < 400) begin tick(); lat++; end
      chk("held_done", {63'd0, done_v[0]}, 64'd1);
      chk("held_id", {40'd0, man_v[0], type_v[0], cap_v[0]}, 64'h202015);
      lat = 0;
      tick();
      while (cs_v[0] && lat < 50) begin tick(); lat++; end
      tick();
      chk("held_gap", 64'(mon_cs_high[0]), 64'(DESEL + 1));
    end
    start_v[0] = 1'b0;
    lat = 0;
    while (!done_v[0] && lat < 400) begin tick(); lat++; end
    repeat (DESEL + 3) tick();
    chk("held_ndone", 64'(mon_dones[0] - d0), 64'd4);

    // Randomized IDs, instances, gaps and interfering start pulses.
    for (int r = 0; r < 8; r++) begin
      ri  = $urandom_range(0, NI - 1);
      rn  = DIVS[ri];
      rid = 24'($urandom);
      rp  = $urandom_range(2, 64 * rn);
      repeat ($urandom_range(0, 10)) tick();
      run_tx(ri, rid, 66 * rn, 66 * rn + 1, rid, rp, -1, $sformatf("rnd%0d", r));
    end

    for (int i = 0; i < NI; i++)
      chk($sformatf("monitor_inst%0d", i), 64'(mon_bad[i]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog");
  end

endmodule
